// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Bundles every non-clock/reset signal of muldiv_ctrl into one interface.
//   Signal names match the controller's port list.
//   Modports:
//     slave  - the controller: takes the EX request, the multiplier product and
//              the divider status; drives operands, stall/busy and HI/LO reads.
//     master - the surrounding logic (EX stage, multiplier, divider), which sees
//              the same signals with the opposite directions.
interface muldiv_ctrl_if;
  // EX-stage request
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  // multiplier
  logic        mul_signed_o;
  logic [31:0] mul_ina_o;
  logic [31:0] mul_inb_o;
  logic [63:0] mul_result_i;
  // divider
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_annul_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  // pipeline status and HI/LO read ports
  logic        stallreq_o;
  logic        busy_o;
  logic [31:0] hi_rdata_o;
  logic [31:0] lo_rdata_o;

  modport slave (
    input  op_valid, op, src1, src2, cancel,
    input  mul_result_i, div_ready_i, div_result_i,
    output mul_signed_o, mul_ina_o, mul_inb_o,
    output div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o, div_annul_o,
    output stallreq_o, busy_o, hi_rdata_o, lo_rdata_o
  );

  modport master (
    output op_valid, op, src1, src2, cancel,
    output mul_result_i, div_ready_i, div_result_i,
    input  mul_signed_o, mul_ina_o, mul_inb_o,
    input  div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o, div_annul_o,
    input  stallreq_o, busy_o, hi_rdata_o, lo_rdata_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequences the shared multiplier and the iterative divider for the EX
//   stage and owns the architectural HI/LO registers
//   (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//   Ports:
//     clk    - clock
//     resetn - asynchronous, active-low reset
//     bus    - muldiv_ctrl_if.slave: EX request (op_valid/op/src1/src2/cancel),
//              multiplier operands and product, divider start/annul/operands,
//              divider ready and result, stallreq_o, busy_o, HI/LO read data.
//   Parameters:
//     MUL_LAT - cycles from operands presented until mul_result_i is valid (>=1)
//     CNT_W   - latency counter width (2**CNT_W > MUL_LAT)
//   Optional build macro:
//     MULDIV_HILO_BYPASS_EN - when defined, hi_rdata_o/lo_rdata_o forward the
//     value being written this cycle; otherwise they show the registers only.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic resetn,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic is_multicycle;
  logic accept;
  logic idle;

  assign idle          = (state_q == IDLE);
  assign is_multicycle = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  // resetn is folded in so that nothing is accepted (and no stall is asked
  // for) while reset is held, even if EX is still presenting an op.
  assign accept        = resetn & bus.op_valid & ~bus.cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                opa_d   = bus.src1;
                opb_d   = bus.src2;
                sgn_d   = (bus.op == OP_MULT);
                cnt_d   = '0;
                state_d = MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.src2 != 32'd0) begin
                  opa_d   = bus.src1;
                  opb_d   = bus.src2;
                  sgn_d   = (bus.op == OP_DIV);
                  state_d = DIV_WAIT;
                end else begin
                  // Divide by zero resolves here without the divider.
                  hi_d    = bus.src1;
                  lo_d    = 32'hFFFF_FFFF;
                  state_d = DONE;
                end
              end
              OP_MTHI: hi_d = bus.src1;
              OP_MTLO: lo_d = bus.src1;
              default: ;
            endcase
          end
        end
        MUL_WAIT: begin
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            {hi_d, lo_d} = bus.mul_result_i;
            cnt_d        = '0;
            state_d      = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DIV_WAIT: begin
          if (bus.div_ready_i) begin
            hi_d    = bus.div_result_i[63:32];
            lo_d    = bus.div_result_i[31:0];
            state_d = DONE;
          end
        end
        // EX advances during DONE; its op is still the one just finished.
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand registers keep their last value in IDLE; mask them so the units
  // see zeros whenever nothing is in flight.
  assign bus.mul_signed_o  = ~idle & sgn_q;
  assign bus.mul_ina_o     = idle ? 32'd0 : opa_q;
  assign bus.mul_inb_o     = idle ? 32'd0 : opb_q;
  assign bus.div_signed_o  = ~idle & sgn_q;
  assign bus.div_opdata1_o = idle ? 32'd0 : opa_q;
  assign bus.div_opdata2_o = idle ? 32'd0 : opb_q;

  assign bus.div_start_o = (state_q == DIV_WAIT) & ~bus.div_ready_i & ~bus.cancel;
  assign bus.div_annul_o = (state_q == DIV_WAIT) & bus.cancel;
  assign bus.busy_o      = ~idle;

  always_comb begin
    case (state_q)
      IDLE:     bus.stallreq_o = accept & is_multicycle;
      MUL_WAIT: bus.stallreq_o = 1'b1;
      DIV_WAIT: bus.stallreq_o = 1'b1;
      default:  bus.stallreq_o = 1'b0;
    endcase
  end

`ifdef MULDIV_HILO_BYPASS_EN
  // hi_d/lo_d equal the registers except in a write cycle, so they double as
  // the forwarded read value.
  assign bus.hi_rdata_o = hi_d;
  assign bus.lo_rdata_o = lo_d;
`else
  assign bus.hi_rdata_o = hi_q;
  assign bus.lo_rdata_o = lo_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Table-driven bench for muldiv_ctrl (MUL_LAT=2) with a one-stage multiplier
//   model and a divider model that raises ready 33 cycles after start.
//   Hand-written sequences cover reset mid-multiply, cancel during a divide,
//   stray divider ready while idle and back-to-back MTHI/MTLO.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_CYC = 33;
  localparam logic [63:0] DIV_JUNK = 64'hBAD0_BAD1_BAD2_BAD3;

  logic clk;
  logic resetn;
  logic force_rdy;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: one register stage, so the product of the operands
  // presented in the first MUL_WAIT cycle is valid in the second.
  logic [63:0] mul_pipe;
  always @(posedge clk) begin
    if (bus.mul_signed_o)
      mul_pipe <= 64'($signed(bus.mul_ina_o) * $signed(bus.mul_inb_o));
    else
      mul_pipe <= {32'd0, bus.mul_ina_o} * {32'd0, bus.mul_inb_o};
  end
  assign bus.mul_result_i = mul_pipe;

  // Divider model.
  int   div_cnt;
  logic div_rdy;
  logic [31:0] q_m, r_m;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= 0;
      div_rdy <= 1'b0;
    end else if (bus.div_start_o) begin
      if (div_cnt == DIV_CYC - 1) div_rdy <= 1'b1;
      div_cnt <= div_cnt + 1;
    end else begin
      div_cnt <= 0;
      div_rdy <= 1'b0;
    end
  end
  always_comb begin
    q_m = 32'd0;
    r_m = 32'd0;
    if (bus.div_opdata2_o != 32'd0) begin
      if (bus.div_signed_o) begin
        q_m = $signed(bus.div_opdata1_o) / $signed(bus.div_opdata2_o);
        r_m = $signed(bus.div_opdata1_o) % $signed(bus.div_opdata2_o);
      end else begin
        q_m = bus.div_opdata1_o / bus.div_opdata2_o;
        r_m = bus.div_opdata1_o % bus.div_opdata2_o;
      end
    end
  end
  assign bus.div_ready_i  = div_rdy | force_rdy;
  assign bus.div_result_i = div_rdy ? {r_m, q_m} : DIV_JUNK;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stalls;
    logic        exp_start;
    logic        exp_sgn;
  } vec_t;

  vec_t vecs[11];

  // Present one op, follow it until EX would advance, then check the result.
  task automatic run_op(input int idx, input vec_t v);
    int   stalls = 0;
    int   guard = 0;
    logic start_seen = 1'b0;
    logic sgn_seen = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = v.op;
    bus.src1     = v.src1;
    bus.src2     = v.src2;
    #1;
    while (bus.stallreq_o && guard < 80) begin
      stalls++;
      start_seen |= bus.div_start_o;
      sgn_seen   |= bus.mul_signed_o | bus.div_signed_o;
      @(negedge clk);
      #1;
      guard++;
    end
    start_seen |= bus.div_start_o;
    if (guard >= 80) check($sformatf("v%0d stall timeout", idx), 64'(guard), 64'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    #1;
    $display("[TB] vec %0d op=%0d src1=%h src2=%h -> hi=%h lo=%h stalls=%0d start=%0b",
             idx, v.op, v.src1, v.src2, bus.hi_rdata_o, bus.lo_rdata_o, stalls, start_seen);
    check($sformatf("v%0d hi", idx), 64'(bus.hi_rdata_o), 64'(v.exp_hi));
    check($sformatf("v%0d lo", idx), 64'(bus.lo_rdata_o), 64'(v.exp_lo));
    check($sformatf("v%0d stalls", idx), 64'(stalls), 64'(v.exp_stalls));
    check($sformatf("v%0d div_start", idx), 64'(start_seen), 64'(v.exp_start));
    check($sformatf("v%0d sign", idx), 64'(sgn_seen), 64'(v.exp_sgn));
    check($sformatf("v%0d busy after", idx), 64'(bus.busy_o), 64'd0);
    check($sformatf("v%0d mul_ina idle", idx), 64'(bus.mul_ina_o), 64'd0);
  endtask

  initial begin
    //          op    src1           src2          hi             lo             st  start sgn
    vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 3,  1'b0, 1'b1};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 3,  1'b0, 1'b0};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 3,  1'b0, 1'b1};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3,  1'b0, 1'b0};
    vecs[4]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        35, 1'b1, 1'b0};
    vecs[5]  = '{3'd3, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 35, 1'b1, 1'b1};
    vecs[6]  = '{3'd3, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1,  1'b0, 1'b0};
    vecs[7]  = '{3'd5, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 0,  1'b0, 1'b0};
    vecs[8]  = '{3'd6, 32'd1,         32'd0,        32'hDEAD_BEEF, 32'd1,         0,  1'b0, 1'b0};
    vecs[9]  = '{3'd7, 32'd123,       32'd9,        32'hDEAD_BEEF, 32'd1,         0,  1'b0, 1'b0};
    vecs[10] = '{3'd0, 32'd456,       32'd9,        32'hDEAD_BEEF, 32'd1,         0,  1'b0, 1'b0};

    resetn       = 1'b0;
    force_rdy    = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.src1     = 32'd0;
    bus.src2     = 32'd0;
    bus.cancel   = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst stall", 64'(bus.stallreq_o), 64'd0);
    check("rst busy", 64'(bus.busy_o), 64'd0);
    check("rst hi", 64'(bus.hi_rdata_o), 64'd0);
    check("rst lo", 64'(bus.lo_rdata_o), 64'd0);
    check("rst div_start", 64'(bus.div_start_o), 64'd0);
    check("rst mul_ina", 64'(bus.mul_ina_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset dropped in the middle of MUL_WAIT.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = 3'd1;
    bus.src1     = 32'd5;
    bus.src2     = 32'd6;
    @(negedge clk);
    #1;
    check("mid-mul busy", 64'(bus.busy_o), 64'd1);
    check("mid-mul ina", 64'(bus.mul_ina_o), 64'd5);
    #1;
    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    #1;
    $display("[TB] reset mid-MUL_WAIT -> busy=%0b stall=%0b hi=%h lo=%h",
             bus.busy_o, bus.stallreq_o, bus.hi_rdata_o, bus.lo_rdata_o);
    check("async rst busy", 64'(bus.busy_o), 64'd0);
    check("async rst stall", 64'(bus.stallreq_o), 64'd0);
    check("async rst hi", 64'(bus.hi_rdata_o), 64'd0);
    check("async rst lo", 64'(bus.lo_rdata_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Main vector table; vector 0 is the MULT that must complete after reset.
    for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

    // Divider ready while idle must be ignored.
    @(negedge clk);
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    #1;
    $display("[TB] stray div_ready in IDLE -> hi=%h lo=%h busy=%0b",
             bus.hi_rdata_o, bus.lo_rdata_o, bus.busy_o);
    check("stray rdy hi", 64'(bus.hi_rdata_o), 64'hDEAD_BEEF);
    check("stray rdy lo", 64'(bus.lo_rdata_o), 64'd1);
    check("stray rdy busy", 64'(bus.busy_o), 64'd0);

    // Cancel in the 10th DIV_WAIT cycle.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = 3'd3;
    bus.src1     = 32'd1000;
    bus.src2     = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (c == 9) check("annul before cancel", 64'(bus.div_annul_o), 64'd0);
    end
    check("div start in flight", 64'(bus.div_start_o), 64'd1);
    bus.cancel = 1'b1;
    #1;
    check("annul on cancel", 64'(bus.div_annul_o), 64'd1);
    @(negedge clk);
    bus.cancel   = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    #1;
    $display("[TB] DIV cancelled -> busy=%0b annul=%0b hi=%h lo=%h",
             bus.busy_o, bus.div_annul_o, bus.hi_rdata_o, bus.lo_rdata_o);
    check("cancel busy", 64'(bus.busy_o), 64'd0);
    check("cancel annul gone", 64'(bus.div_annul_o), 64'd0);
    check("cancel hi", 64'(bus.hi_rdata_o), 64'hDEAD_BEEF);
    check("cancel lo", 64'(bus.lo_rdata_o), 64'd1);

    // Back-to-back MTHI/MTLO, checking read visibility in the write cycle.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = 3'd5;
    bus.src1     = 32'hCAFE_F00D;
    #1;
    check("mthi stall", 64'(bus.stallreq_o), 64'd0);
`ifdef MULDIV_HILO_BYPASS_EN
    check("mthi bypass hi", 64'(bus.hi_rdata_o), 64'hCAFE_F00D);
`else
    check("mthi write-cycle hi", 64'(bus.hi_rdata_o), 64'hDEAD_BEEF);
`endif
    @(negedge clk);
    bus.op   = 3'd6;
    bus.src1 = 32'd77;
    #1;
    check("mtlo stall", 64'(bus.stallreq_o), 64'd0);
    check("mthi visible", 64'(bus.hi_rdata_o), 64'hCAFE_F00D);
`ifdef MULDIV_HILO_BYPASS_EN
    check("mtlo bypass lo", 64'(bus.lo_rdata_o), 64'd77);
`else
    check("mtlo write-cycle lo", 64'(bus.lo_rdata_o), 64'd1);
`endif
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    #1;
    $display("[TB] MTHI/MTLO back-to-back -> hi=%h lo=%h", bus.hi_rdata_o, bus.lo_rdata_o);
    check("mtlo visible", 64'(bus.lo_rdata_o), 64'd77);
    check("mthi kept", 64'(bus.hi_rdata_o), 64'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequences the shared multiplier and iterative divider on behalf of the EX stage, and owns the architectural HI/LO registers. It handles MULT/MULTU/DIV/DIVU/MTHI/MTLO:
- captures operands and drives the mul/div units;
- raises a stall request while a multi-cycle op is in flight;
- commits the 64-bit result to HI/LO.
Sits beside EX; its stall request is ORed into the EX-stage stall request.

Parameters:
MUL_LAT, 2, cycles from operands presented to the multiplier until mul_result_i is valid (>=1)
CNT_W, 3, width of latency counter (2^CNT_W > MUL_LAT)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
op_valid  in  1  EX holds a mul/div/HI-LO op; held stable while stallreq_o=1
op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
src1  in  32  rs operand
src2  in  32  rt operand
cancel  in  1  flush; aborts any op in flight
mul_signed_o  out  1  signed multiply select
mul_ina_o  out  32  multiplier operand A
mul_inb_o  out  32  multiplier operand B
mul_result_i  in  64  multiplier product
div_start_o  out  1  divider start, held until ready
div_signed_o  out  1  signed divide select
div_opdata1_o  out  32  dividend
div_opdata2_o  out  32  divisor
div_annul_o  out  1  divider abort pulse
div_ready_i  in  1  divider result valid
div_result_i  in  64  {remainder, quotient}
stallreq_o  out  1  stall EX and earlier stages
busy_o  out  1  state != IDLE
hi_rdata_o  out  32  HI value for MFHI
lo_rdata_o  out  32  LO value for MFLO

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Reset (resetn=0, async): state=IDLE, counter=0, operand regs=0, HI=LO=0. All outputs 0.
- Operand registers opa/opb/sgn are captured on a launch edge. mul_ina/inb/signed and div_opdata1/2/signed are driven from these registers; they read 0 while IDLE.
- IDLE (cancel=0, op_valid=1):
  - op 1/2: capture operands, sgn=(op==1), counter=0, go MUL_WAIT.
  - op 3/4 with src2!=0: capture, sgn=(op==3), go DIV_WAIT.
  - op 3/4 with src2==0: HI<=src1, LO<=32'hFFFF_FFFF, go DONE; divider not started.
  - op 5: HI<=src1. op 6: LO<=src1. Both stay in IDLE with no stall.
- stallreq_o is combinational: 1 in IDLE when op_valid & op in 1..4 & ~cancel; 1 in MUL_WAIT; 1 in DIV_WAIT; 0 in DONE.
- MUL_WAIT:
  - counter increments each cycle.
  - When counter==MUL_LAT-1: {HI,LO}<=mul_result_i, go DONE. MUL_WAIT lasts exactly MUL_LAT cycles.
- DIV_WAIT:
  - div_start_o=1 while div_ready_i=0.
  - When div_ready_i=1: div_start_o=0, HI<=div_result_i[63:32], LO<=div_result_i[31:0], go DONE.
- DONE: one cycle with stall low so EX advances. op_valid/op is ignored (same instruction). Always go to IDLE. A new op may launch in the following IDLE cycle.
- cancel=1 in any state:
  - next state IDLE; no HI/LO write that cycle; counter cleared.
  - div_annul_o=1 for that cycle if state is DIV_WAIT, else 0.
  - In IDLE, cancel suppresses launch and mthi/mtlo writes.
- div_ready_i outside DIV_WAIT: ignored. mul_result_i outside the final MUL_WAIT cycle: ignored.
- Multiply result is the full 64-bit product; signedness is selected only by sgn.

Optional Feature:
MULDIV_HILO_BYPASS_EN.
- Defined: hi_rdata_o/lo_rdata_o combinationally show the value being written in the current cycle (mthi/mtlo in IDLE, final MUL_WAIT cycle, div-ready cycle, div-by-zero launch). Otherwise they show the registers.
- Undefined: hi_rdata_o/lo_rdata_o are the HI/LO registers only; a write is visible the cycle after.

Test Plan:
- MULT src1=-3, src2=7, MUL_LAT=2, model mul returns product after 2 cycles -> stallreq high for 3 cycles (launch + 2 MUL_WAIT), then DONE; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIVU src1=100, src2=7, model divider asserts ready 33 cycles after start -> div_start_o high until ready, div_signed_o=0; HI=2, LO=14; DONE one cycle, then IDLE.
- DIV src1=5, src2=0 -> no div_start_o; HI=5, LO=32'hFFFF_FFFF; stallreq high 1 cycle.
- DIV in flight, cancel at 10th DIV_WAIT cycle -> div_annul_o=1 one cycle, state IDLE next, HI/LO unchanged.
- MTHI src1=32'hDEAD_BEEF, then MTLO src1=1 back-to-back -> no stall; HI=32'hDEAD_BEEF, LO=1. With bypass enabled, hi_rdata_o=32'hDEAD_BEEF in the write cycle.
- resetn dropped mid-MUL_WAIT -> immediately IDLE, stallreq_o=0, HI=LO=0; MULT after resetn rises completes normally.
